de_issue_ctrl: RTL and testbench

DE_ISSUE_CTRL -- requirements
Module: de_issue_ctrl

---
 rtl/de_issue_ctrl_pkg.sv | 14 +
 rtl/defines.sv | 7 +
 rtl/rob_alloc_tracker.sv | 77 +++++++
 rtl/de_issue_ctrl.sv | 101 ++++++++++
 tb/tb_de_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/de_issue_ctrl_pkg.sv
// Common constants for the decode/issue controller and its bench.
`ifndef DE_DEFINES_SV
`include "defines.sv"
`endif

package de_issue_ctrl_pkg;

  localparam int unsigned INSTR_TYPE_W = `INSTR_TYPE_SZ;
  localparam logic [INSTR_TYPE_W-1:0] INSTR_TYPE_MUL_C = `INSTR_TYPE_MUL;

  // Wide enough for the largest legal MUL_LATENCY-1 (14).
  localparam int unsigned BUSY_CNT_W = 4;

endpackage

// File: rtl/defines.sv
// Shared project-wide defines for the decode/issue front end.
`ifndef DE_DEFINES_SV
`define DE_DEFINES_SV
`define INSTR_TYPE_SZ   4
`define INSTR_TYPE_MUL  4'd3
`define ROB_ENTRY_WIDTH 3
`endif

// File: rtl/rob_alloc_tracker.sv
// ROB head/tail/occupancy bookkeeping with flush collapse and sticky underflow flag.
`ifndef DE_DEFINES_SV
`include "defines.sv"
`endif

module rob_alloc_tracker #(
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_i,
  input  logic                       commit_i,
  input  logic                       flush_i,
  output logic [ROB_ENTRY_WIDTH-1:0] tail_o,
  output logic [ROB_ENTRY_WIDTH:0]   count_o,
  output logic                       full_o,
  output logic                       err_underflow_o
);

  localparam logic [ROB_ENTRY_WIDTH:0] FULL_COUNT = {1'b1, {ROB_ENTRY_WIDTH{1'b0}}};

  logic [ROB_ENTRY_WIDTH-1:0] head_q, head_d;
  logic [ROB_ENTRY_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_ENTRY_WIDTH:0]   count_q, count_d;
  logic                       err_q, err_d;
  logic                       empty;
  logic                       commit_ok;

  assign empty     = (count_q == '0);
  assign commit_ok = commit_i && !empty;

  // NOTE: every signal written here gets a default first, otherwise paths that
  // skip an assignment infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | (commit_i && empty);

    if (commit_ok) head_d = head_q + 1'b1;

    // A flush discards every allocated entry: tail snaps to the post-commit head.
    if (flush_i) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (alloc_i) tail_d = tail_q + 1'b1;
      case ({alloc_i, commit_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign tail_o          = tail_q;
  assign count_o         = count_q;
  assign full_o          = (count_q == FULL_COUNT);
  assign err_underflow_o = err_q;

endmodule

// File: rtl/de_issue_ctrl.sv
// Decode-to-execute issue control: ROB allocation, MUL occupancy stall and flush handling.
`ifndef DE_DEFINES_SV
`include "defines.sv"
`endif

module de_issue_ctrl
  import de_issue_ctrl_pkg::*;
#(
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int MUL_LATENCY     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   dec_instr_type,
  input  logic                       rob_commit,
  input  logic                       flush,
  output logic                       dec_stall,
  output logic                       de_valid,
  output logic                       de_stall,
  output logic                       de_reset,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic [ROB_ENTRY_WIDTH:0]   rob_count,
  output logic                       err_underflow
);

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  localparam logic [BUSY_CNT_W-1:0] BUSY_LOAD = BUSY_CNT_W'(MUL_LATENCY - 1);
  localparam logic [INSTR_TYPE_SZ-1:0] MUL_TYPE = INSTR_TYPE_SZ'(`INSTR_TYPE_MUL);

  state_e                     state_q;
  logic [BUSY_CNT_W-1:0]      busy_cnt_q;
  logic                       busy;
  logic                       rob_full;
  logic                       issue;
  logic                       is_mul;
  logic [ROB_ENTRY_WIDTH-1:0] tail;
  logic [ROB_ENTRY_WIDTH:0]   count;
  logic                       err;

  assign busy   = (state_q == MUL_BUSY);
  assign is_mul = (dec_instr_type == MUL_TYPE);

  // Outputs are forced to their idle values while reset is high, even though
  // the registers only clear at the following edge.
  assign dec_stall = !reset && (rob_full || busy);
  assign issue     = !reset && dec_valid && !dec_stall && !flush;

  assign de_valid      = issue;
  assign de_stall      = !reset && busy;
  assign de_reset      = flush || reset;
  assign rob_id        = reset ? '0 : tail;
  assign rob_count     = reset ? '0 : count;
  assign err_underflow = !reset && err;

  rob_alloc_tracker #(
    .ROB_ENTRY_WIDTH(ROB_ENTRY_WIDTH)
  ) u_rob_alloc_tracker (
    .clk            (clk),
    .reset          (reset),
    .alloc_i        (issue),
    .commit_i       (rob_commit),
    .flush_i        (flush),
    .tail_o         (tail),
    .count_o        (count),
    .full_o         (rob_full),
    .err_underflow_o(err)
  );

  // The busy counter holds the number of stall cycles still to come, including this one.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue && is_mul) begin
            state_q    <= MUL_BUSY;
            busy_cnt_q <= BUSY_LOAD;
          end
        end
        MUL_BUSY: begin
          if (busy_cnt_q <= BUSY_CNT_W'(1)) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
          end else begin
            busy_cnt_q <= busy_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de_issue_ctrl.sv
// Bench for de_issue_ctrl: directed vector table, corner sequences, random run against a queue model.
module tb_de_issue_ctrl;
  import de_issue_ctrl_pkg::*;

  localparam int W     = 3;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int ALU   = 0;
  localparam int MUL   = int'(INSTR_TYPE_MUL_C);

  typedef struct packed {
    logic                    rst;
    logic                    dv;
    logic [INSTR_TYPE_W-1:0] ty;
    logic                    cm;
    logic                    fl;
  } in_t;

  typedef struct packed {
    logic         dec_stall;
    logic         de_valid;
    logic         de_stall;
    logic         de_reset;
    logic [W-1:0] rob_id;
    logic [W:0]   rob_count;
    logic         err;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic                    clk;
  logic                    reset;
  logic                    dec_valid;
  logic [INSTR_TYPE_W-1:0] dec_instr_type;
  logic                    rob_commit;
  logic                    flush;
  logic                    dec_stall;
  logic                    de_valid;
  logic                    de_stall;
  logic                    de_reset;
  logic [W-1:0]            rob_id;
  logic [W:0]              rob_count;
  logic                    err_underflow;

  int checks   = 0;
  int failures = 0;

  de_issue_ctrl #(
    .INSTR_TYPE_SZ  (INSTR_TYPE_W),
    .ROB_ENTRY_WIDTH(W),
    .MUL_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_instr_type(dec_instr_type),
    .rob_commit    (rob_commit),
    .flush         (flush),
    .dec_stall     (dec_stall),
    .de_valid      (de_valid),
    .de_stall      (de_stall),
    .de_reset      (de_reset),
    .rob_id        (rob_id),
    .rob_count     (rob_count),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight ROB ids as a queue, plus remaining MUL stall cycles.
  int q_m[$];
  int head_m;
  int tail_m;
  int stall_left_m;
  bit err_m;

  function automatic out_t model_out(input in_t in);
    out_t o;
    bit   full;
    full        = (q_m.size() == DEPTH);
    o.dec_stall = !in.rst && (full || stall_left_m > 0);
    o.de_valid  = !in.rst && in.dv && !o.dec_stall && !in.fl;
    o.de_stall  = !in.rst && stall_left_m > 0;
    o.de_reset  = in.rst || in.fl;
    o.rob_id    = in.rst ? '0 : W'(tail_m);
    o.rob_count = in.rst ? '0 : (W+1)'(q_m.size());
    o.err       = !in.rst && err_m;
    return o;
  endfunction

  task automatic model_step(input in_t in);
    out_t o;
    o = model_out(in);
    if (in.rst) begin
      q_m.delete();
      head_m = 0; tail_m = 0; stall_left_m = 0; err_m = 1'b0;
    end else begin
      if (in.cm) begin
        if (q_m.size() > 0) begin
          void'(q_m.pop_front());
          head_m = (head_m + 1) % DEPTH;
        end else begin
          err_m = 1'b1;
        end
      end
      if (in.fl) begin
        q_m.delete();
        tail_m = head_m;
        stall_left_m = 0;
      end else begin
        if (stall_left_m > 0) stall_left_m--;
        if (o.de_valid) begin
          q_m.push_back(tail_m);
          tail_m = (tail_m + 1) % DEPTH;
          if (int'(in.ty) == MUL) stall_left_m = LAT - 1;
        end
      end
    end
  endtask

  function automatic in_t mk_in(input bit rst, input bit dv, input int ty, input bit cm, input bit fl);
    in_t i;
    i.rst = rst; i.dv = dv; i.ty = INSTR_TYPE_W'(ty); i.cm = cm; i.fl = fl;
    return i;
  endfunction

  function automatic out_t mk_out(input bit ds, input bit dv, input bit dst, input bit drs,
                                  input int id, input int cnt, input bit e);
    out_t o;
    o.dec_stall = ds; o.de_valid = dv; o.de_stall = dst; o.de_reset = drs;
    o.rob_id = W'(id); o.rob_count = (W+1)'(cnt); o.err = e;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got ds=%b dv=%b dst=%b drs=%b id=%0d cnt=%0d err=%b required ds=%b dv=%b dst=%b drs=%b id=%0d cnt=%0d err=%b",
               name, $time, got.dec_stall, got.de_valid, got.de_stall, got.de_reset, got.rob_id,
               got.rob_count, got.err, exp.dec_stall, exp.de_valid, exp.de_stall, exp.de_reset,
               exp.rob_id, exp.rob_count, exp.err);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance model on the rising edge.
  task automatic apply(input in_t in, input out_t exp, input string name);
    out_t got;
    reset          = in.rst;
    dec_valid      = in.dv;
    dec_instr_type = in.ty;
    rob_commit     = in.cm;
    flush          = in.fl;
    @(negedge clk);
    got = '{dec_stall, de_valid, de_stall, de_reset, rob_id, rob_count, err_underflow};
    check(name, got, exp);
    @(posedge clk);
    model_step(in);
    #1;
  endtask

  vec_t tbl[$];

  task automatic add(input in_t i, input out_t o, input string name);
    vec_t v;
    v.i = i; v.o = o; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    in_t i;
    reset = 1'b1; dec_valid = 1'b0; dec_instr_type = '0; rob_commit = 1'b0; flush = 1'b0;
    head_m = 0; tail_m = 0; stall_left_m = 0; err_m = 1'b0;
    @(posedge clk);
    #1;

    // Fill the ROB with back-to-back ALU issues, then free one slot.
    add(mk_in(1, 1, ALU, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0), "reset_state");
    for (int k = 0; k < DEPTH; k++)
      add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, k, k, 0), $sformatf("fill_%0d", k));
    add(mk_in(0, 1, ALU, 0, 0), mk_out(1, 0, 0, 0, 0, 8, 0), "full_stall");
    add(mk_in(0, 0, ALU, 1, 0), mk_out(1, 0, 0, 0, 0, 8, 0), "full_commit");
    add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 0, 7, 0), "after_commit");
    add(mk_in(1, 0, ALU, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0), "reset_full");
    // MUL occupancy, issue+commit, drain, underflow, flush.
    add(mk_in(0, 1, MUL, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0), "mul_issue");
    for (int k = 1; k < LAT; k++)
      add(mk_in(0, 1, ALU, 0, 0), mk_out(1, 0, 1, 0, 1, 1, 0), $sformatf("mul_busy_%0d", k));
    add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 1, 1, 0), "mul_done_issue");
    add(mk_in(0, 1, ALU, 1, 0), mk_out(0, 1, 0, 0, 2, 2, 0), "issue_commit");
    add(mk_in(0, 0, ALU, 1, 0), mk_out(0, 0, 0, 0, 3, 2, 0), "drain_2");
    add(mk_in(0, 0, ALU, 1, 0), mk_out(0, 0, 0, 0, 3, 1, 0), "drain_1");
    add(mk_in(0, 0, ALU, 1, 0), mk_out(0, 0, 0, 0, 3, 0, 0), "underflow_commit");
    add(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 3, 0, 1), "underflow_sticky");
    add(mk_in(0, 1, ALU, 0, 1), mk_out(0, 0, 0, 1, 3, 0, 1), "flush_idle");
    add(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 3, 0, 1), "after_flush");
    add(mk_in(1, 0, ALU, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0), "reset_err");
    add(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0), "err_cleared");
    // Flush in the second MUL_BUSY cycle with three entries and a same-cycle commit.
    add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0), "pre_a0");
    add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 1, 1, 0), "pre_a1");
    add(mk_in(0, 1, MUL, 0, 0), mk_out(0, 1, 0, 0, 2, 2, 0), "pre_mul");
    add(mk_in(0, 0, ALU, 0, 0), mk_out(1, 0, 1, 0, 3, 3, 0), "busy_1");
    add(mk_in(0, 1, ALU, 1, 1), mk_out(1, 0, 1, 1, 3, 3, 0), "busy_flush");
    add(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 1, 0, 0), "post_flush_issue");

    foreach (tbl[n]) apply(tbl[n].i, tbl[n].o, tbl[n].name);

    // Issue and commit together at rob_count=5; head advance shows up after a flush.
    apply(mk_in(1, 0, ALU, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0), "seq36_reset");
    for (int k = 0; k < 5; k++)
      apply(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, k, k, 0), "seq36_fill");
    apply(mk_in(0, 1, ALU, 1, 0), mk_out(0, 1, 0, 0, 5, 5, 0), "seq36_both");
    apply(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 6, 5, 0), "seq36_hold");
    apply(mk_in(0, 0, ALU, 0, 1), mk_out(0, 0, 0, 1, 6, 5, 0), "seq36_flush");
    apply(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 1, 0, 0), "seq36_head");

    // One-cycle reset in the middle of a multiply.
    apply(mk_in(0, 1, MUL, 0, 0), mk_out(0, 1, 0, 0, 1, 0, 0), "seq39_mul");
    apply(mk_in(0, 1, ALU, 0, 0), mk_out(1, 0, 1, 0, 2, 1, 0), "seq39_busy");
    apply(mk_in(1, 1, ALU, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0), "seq39_reset");
    apply(mk_in(0, 1, ALU, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0), "seq39_issue");
    apply(mk_in(0, 0, ALU, 0, 0), mk_out(0, 0, 0, 0, 1, 1, 0), "seq39_after");

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      i = mk_in($urandom_range(0, 63) == 0,
                $urandom_range(0, 9) < 7,
                ($urandom_range(0, 4) == 0) ? MUL : int'($urandom_range(0, (1 << INSTR_TYPE_W) - 1)),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 24) == 0);
      apply(i, model_out(i), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
